// File: rtl/uart_apb_scheduler.sv
// APB master sequencer for the UART: four-write init sequence after reset, then
// round-robin sharing between TX (port 0) and RX/status (port 1). Optional macro: UART_APB_TIMEOUT_EN.
module uart_apb_scheduler #(
  parameter int              ADDR_W  = 6,
  parameter logic [ADDR_W-1:0] INIT_A0 = 6'h0C,
  parameter logic [7:0]      INIT_D0 = 8'h83,
  parameter logic [ADDR_W-1:0] INIT_A1 = 6'h00,
  parameter logic [7:0]      INIT_D1 = 8'h1B,
  parameter logic [ADDR_W-1:0] INIT_A2 = 6'h04,
  parameter logic [7:0]      INIT_D2 = 8'h00,
  parameter logic [ADDR_W-1:0] INIT_A3 = 6'h0C,
  parameter logic [7:0]      INIT_D3 = 8'h03
`ifdef UART_APB_TIMEOUT_EN
  , parameter int            TIMEOUT = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic              apb_psel_o,
  output logic              apb_penable_o,
  output logic              apb_pwrite_o,
  output logic [ADDR_W-1:0] apb_paddr_o,
  output logic [31:0]       apb_pwdata_o,
  input  logic              apb_pready_i,
  input  logic              apb_pslverr_i,
  input  logic [31:0]       apb_prdata_i,
  output logic              init_done
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              init_done_q, init_done_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic              pick_s, accept_s, done_s;
`ifdef UART_APB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]        cnt_q, cnt_d;
`endif

  function automatic logic [ADDR_W-1:0] init_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    init_addr = INIT_A0;
      2'd1:    init_addr = INIT_A1;
      2'd2:    init_addr = INIT_A2;
      default: init_addr = INIT_A3;
    endcase
  endfunction

  function automatic logic [7:0] init_data(input logic [1:0] idx);
    case (idx)
      2'd0:    init_data = INIT_D0;
      2'd1:    init_data = INIT_D1;
      2'd2:    init_data = INIT_D2;
      default: init_data = INIT_D3;
    endcase
  endfunction

  // A tie goes to the port that was not served last; RESP accepts like IDLE.
  assign pick_s   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign accept_s = ~rst & ((state_q == S_IDLE) | (state_q == S_RESP)) & (req0_valid | req1_valid);

  assign req0_ready    = accept_s & ~pick_s;
  assign req1_ready    = accept_s & pick_s;
  assign rsp0_valid    = rsp0_valid_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp0_rdata    = rdata_q;
  assign rsp1_rdata    = rdata_q;
  assign rsp0_err      = err_q;
  assign rsp1_err      = err_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = write_q;
  assign apb_paddr_o   = addr_q;
  assign apb_pwdata_o  = wdata_q;
  assign init_done     = init_done_q;

  // Next-state, transfer capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    done_s      = 1'b0;
`ifdef UART_APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_INIT: begin
        write_d = 1'b1;
        addr_d  = init_addr(idx_q);
        wdata_d = {24'h0, init_data(idx_q)};
        state_d = S_SETUP;
      end
      S_IDLE, S_RESP: begin
        if (accept_s) begin
          gnt_d   = pick_s;
          last_d  = pick_s;
          write_d = pick_s ? req1_write : req0_write;
          addr_d  = pick_s ? req1_addr  : req0_addr;
          wdata_d = pick_s ? req1_wdata : req0_wdata;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef UART_APB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_ACCESS: begin
        if (apb_pready_i) begin
          done_s  = 1'b1;
          rdata_d = write_q ? 32'h0 : apb_prdata_i;
          err_d   = apb_pslverr_i;
        end
`ifdef UART_APB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          done_s  = 1'b1;
          rdata_d = 32'h0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        else begin
          done_s = 1'b0;
        end
`endif
        // Init completions (including errors) just advance the sequence.
        if (done_s) begin
          if (!init_done_q) begin
            if (idx_q == 2'd3) begin
              init_done_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = S_INIT;
            end
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      default: state_d = S_INIT;
    endcase
    psel_d       = (state_d == S_SETUP) | (state_d == S_ACCESS);
    penable_d    = (state_d == S_ACCESS);
    rsp0_valid_d = (state_d == S_RESP) & ~gnt_d;
    rsp1_valid_d = (state_d == S_RESP) & gnt_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_INIT;
      idx_q        <= 2'd0;
      init_done_q  <= 1'b0;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef UART_APB_TIMEOUT_EN
      cnt_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      init_done_q  <= init_done_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
`ifdef UART_APB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_apb_scheduler.sv
// Randomized bench for uart_apb_scheduler: a transaction-level schedule model predicts
// every APB phase, grant and response cycle by cycle.
module tb_uart_apb_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
  logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
  logic [5:0]  req0_addr, req1_addr, apb_paddr_o;
  logic [31:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata, apb_pwdata_o, apb_prdata_i;
  logic        apb_psel_o, apb_penable_o, apb_pwrite_o, apb_pready_i, apb_pslverr_i, init_done;

  uart_apb_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o),
    .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i), .apb_prdata_i(apb_prdata_i),
    .init_done(init_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rst_smp = 1'b1;

  // Model of the one transfer in flight: accepted at cycle acc, w wait states.
  bit          act, a_init, a_to, a_port, a_wr, last, force_to;
  int          acc, w, free_cyc, init_k, pct, maxw;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata, s_rdata;
  bit          s_err;
  bit          hold [2];
  bit          h_wr [2];
  logic [5:0]  h_addr [2];
  logic [31:0] h_wdata [2];
  logic [5:0]  ia [4] = '{6'h0C, 6'h00, 6'h04, 6'h0C};
  logic [7:0]  id [4] = '{8'h83, 8'h1B, 8'h00, 8'h03};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic restart_model();
    cyc = 0; act = 1'b0; init_k = 0; free_cyc = 12; last = 1'b1;
  endtask

  // Inputs for cycle cyc: init schedule, slave response, requester traffic.
  task automatic drive();
    if (act && a_init && cyc == acc + 3) act = 1'b0;
    if (!act && init_k < 4 && cyc == 3 * init_k) begin
      act = 1'b1; a_init = 1'b1; a_to = 1'b0; acc = cyc; w = 0; a_wr = 1'b1;
      a_addr = ia[init_k]; a_wdata = {24'h0, id[init_k]}; init_k++;
    end
    apb_pready_i = act && !a_to && cyc == acc + 2 + w;
    if (apb_pready_i) begin
      s_rdata = $urandom; s_err = ($urandom_range(0, 3) == 0);
      apb_prdata_i = s_rdata; apb_pslverr_i = s_err;
    end else begin
      apb_prdata_i = $urandom; apb_pslverr_i = 1'($urandom_range(0, 1));
    end
    for (int p = 0; p < 2; p++) begin
      if (!hold[p] && $urandom_range(0, 99) < pct) begin
        hold[p] = 1'b1; h_wr[p] = 1'($urandom_range(0, 1));
        h_addr[p] = 6'($urandom_range(0, 63)); h_wdata[p] = $urandom;
      end
    end
    req0_valid = hold[0]; req0_write = h_wr[0]; req0_addr = h_addr[0]; req0_wdata = h_wdata[0];
    req1_valid = hold[1]; req1_write = h_wr[1]; req1_addr = h_addr[1]; req1_wdata = h_wdata[1];
  endtask

  task automatic monitor();
    bit ep, ee, r0, r1, any_g, pk;
    if (rst_smp) begin
      check_eq("rst_ctrl", 32'({apb_psel_o, apb_penable_o, apb_pwrite_o, req0_ready, req1_ready,
               rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, init_done}), 32'h0);
      check_eq("rst_paddr", 32'(apb_paddr_o), 32'h0);
      check_eq("rst_pwdata", apb_pwdata_o, 32'h0);
      check_eq("rst_rdata", rsp0_rdata | rsp1_rdata, 32'h0);
    end else begin
      ep = act && cyc >= acc + 1 && cyc <= acc + 2 + w;
      ee = act && cyc >= acc + 2 && cyc <= acc + 2 + w;
      check_eq("psel", 32'(apb_psel_o), 32'(ep));
      check_eq("penable", 32'(apb_penable_o), 32'(ee));
      if (ep) begin
        check_eq("paddr", 32'(apb_paddr_o), 32'(a_addr));
        check_eq("pwdata", apb_pwdata_o, a_wdata);
        check_eq("pwrite", 32'(apb_pwrite_o), 32'(a_wr));
      end
      r0 = act && !a_init && cyc == acc + 3 + w && !a_port;
      r1 = act && !a_init && cyc == acc + 3 + w && a_port;
      check_eq("rsp0_valid", 32'(rsp0_valid), 32'(r0));
      check_eq("rsp1_valid", 32'(rsp1_valid), 32'(r1));
      if (r0 || r1) begin
        check_eq(r0 ? "rsp0_rdata" : "rsp1_rdata", r0 ? rsp0_rdata : rsp1_rdata,
                 (a_wr || a_to) ? 32'h0 : s_rdata);
        check_eq(r0 ? "rsp0_err" : "rsp1_err", 32'(r0 ? rsp0_err : rsp1_err), 32'(a_to ? 1'b1 : s_err));
        act = 1'b0;
      end
      check_eq("init_done", 32'(init_done), 32'(cyc >= 12));
      any_g = !rst && cyc >= free_cyc && (hold[0] || hold[1]);
      pk = (hold[0] && hold[1]) ? !last : hold[1];
      check_eq("req0_ready", 32'(req0_ready), 32'(any_g && !pk));
      check_eq("req1_ready", 32'(req1_ready), 32'(any_g && pk));
      if (any_g) begin
        act = 1'b1; a_init = 1'b0; a_to = 1'b0; a_port = pk; acc = cyc;
        a_wr = h_wr[pk]; a_addr = h_addr[pk]; a_wdata = h_wdata[pk];
        w = $urandom_range(0, maxw);
        if (force_to) begin
          a_to = 1'b1; w = 254; force_to = 1'b0;
        end
        hold[pk] = 1'b0; last = pk; free_cyc = cyc + 3 + w;
      end
    end
  endtask

  task automatic cycle_end();
    @(negedge clk);
    monitor();
    @(posedge clk);
    rst_smp = rst;
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      cycle_end();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    apb_pready_i = 1'b0;
    repeat (n) cycle_end();
    rst = 1'b0;
    restart_model();
  endtask

  initial begin
    int guard;
    rst = 1'b1; apb_pready_i = 1'b0; apb_pslverr_i = 1'b0; apb_prdata_i = 32'h0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 6'h0; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 6'h0; req1_wdata = 32'h0;
    hold[0] = 1'b0; hold[1] = 1'b0; force_to = 1'b0;
    pct = 100; maxw = 0;
    restart_model();
    @(posedge clk);
    #1;
    do_reset(3);
    // Both ports pending through init, then saturated zero-wait traffic.
    run(40);
    pct = 45; maxw = 3;
    run(400);
    pct = 100; maxw = 2;
    guard = 0;
    while (!(act && !a_init && cyc == acc + 2) && guard < 200) begin
      drive();
      cycle_end();
      guard++;
    end
    check_eq("mid_access_reached", 32'(guard < 200), 32'h1);
    rst = 1'b1;
    drive();
    cycle_end();
    do_reset(2);
    run(60);
`ifdef UART_APB_TIMEOUT_EN
    pct = 0;
    run(10);
    force_to = 1'b1;
    hold[0] = 1'b1; h_wr[0] = 1'b0; h_addr[0] = 6'h14; h_wdata[0] = 32'h0;
    run(270);
    pct = 30; maxw = 1;
    run(60);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
